// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping-coherence bus arbiter.
// Holds the default field widths, the sequencer state encoding, the
// {write, read} op encoding, and a helper that classifies an op as legal.
package snoop_pkg;

  localparam int TAG_W_DEF  = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Op encoding as {write, read}; 2'b00 and 2'b11 are illegal.
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b01;

  function automatic logic op_legal(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports:
//   req_i     in  N_REQ           request vector
//   rr_ptr_i  in  clog2(N_REQ)    highest-priority index for this arbitration
//   grant_o   out clog2(N_REQ)    first set request at or after rr_ptr_i (wrapping)
//   any_req_o out 1               at least one request is set
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr_i,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     any_req_o
);

  localparam int             IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W:0] N_L   = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;

  // Walk the requesters starting at rr_ptr_i; the first set bit wins.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int j = 0; j < N_REQ; j++) begin
      // rr_ptr_i < N_REQ, so one conditional subtract is enough to wrap.
      sum_s = {1'b0, rr_ptr_i} + (IDX_W+1)'(j);
      if (sum_s >= N_L) begin
        idx_s = IDX_W'(sum_s - N_L);
      end else begin
        idx_s = sum_s[IDX_W-1:0];
      end
      if (!found_s && req_i[idx_s]) begin
        found_s = 1'b1;
        grant_o = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Shared snoop-bus arbiter and transaction sequencer.
// Picks one of N_REQ requesters round-robin, drives its transaction onto the
// broadcast bus until bus_done or a timeout, then pulses req_ack to the owner.
// Ports:
//   clock, reset_n                  clock / async active-low reset
//   req_valid/write/read [N_REQ]    per-requester request and op
//   req_tag  [N_REQ*TAG_W]          flattened tags, requester i at [i*TAG_W +: TAG_W]
//   req_data [N_REQ*DATA_W]         flattened write data, same packing
//   req_ack  [N_REQ]                one-cycle completion pulse to the owner
//   req_err, req_rdata              status/read data qualified by req_ack
//   bus_valid/write/read/tag/data   broadcast transaction (bus_valid qualifies)
//   bus_owner                       index of the granted requester
//   bus_done, rsp_data              completion and read data from memory/snoop side
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ-1:0]         req_read,
  input  logic [N_REQ*TAG_W-1:0]   req_tag,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         req_ack,
  output logic                     req_err,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     bus_valid,
  output logic                     bus_write,
  output logic                     bus_read,
  output logic [TAG_W-1:0]         bus_tag,
  output logic [DATA_W-1:0]        bus_data,
  output logic [$clog2(N_REQ)-1:0] bus_owner,
  input  logic                     bus_done,
  input  logic [DATA_W-1:0]        rsp_data
);

  localparam int               IDX_W    = $clog2(N_REQ);
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ACK_ONE  = N_REQ'(1);

  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]    owner_q,     owner_d;
  logic                write_q,     write_d;
  logic                read_q,      read_d;
  logic [TAG_W-1:0]    tag_q,       tag_d;
  logic [DATA_W-1:0]   data_q,      data_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                bus_valid_q, bus_valid_d;
  logic [N_REQ-1:0]    ack_q,       ack_d;
  logic                err_q,       err_d;
  logic [DATA_W-1:0]   rdata_q,     rdata_d;

  logic [IDX_W-1:0]    grant_s;
  logic                any_req_s;
  logic                sel_write_s;
  logic                sel_read_s;
  logic [TAG_W-1:0]    sel_tag_s;
  logic [DATA_W-1:0]   sel_data_s;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (grant_s),
    .any_req_o (any_req_s)
  );

  // Mux the winning requester's op, tag and data out of the flattened buses.
  always_comb begin
    sel_write_s = 1'b0;
    sel_read_s  = 1'b0;
    sel_tag_s   = '0;
    sel_data_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s == IDX_W'(i)) begin
        sel_write_s = req_write[i];
        sel_read_s  = req_read[i];
        sel_tag_s   = req_tag[i*TAG_W +: TAG_W];
        sel_data_s  = req_data[i*DATA_W +: DATA_W];
      end else begin
        sel_write_s = sel_write_s;
      end
    end
  end

  // Next-state logic for the sequencer and all of its registered outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    write_d     = write_q;
    read_d      = read_q;
    tag_d       = tag_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    bus_valid_d = bus_valid_q;
    ack_d       = '0;
    err_d       = err_q;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        bus_valid_d = 1'b0;
        if (any_req_s) begin
          owner_d = grant_s;
          write_d = sel_write_s;
          read_d  = sel_read_s;
          tag_d   = sel_tag_s;
          data_d  = sel_data_s;
          if (!op_legal({sel_write_s, sel_read_s})) begin
            // Illegal op never reaches the bus; ack with error right away.
            state_d = ACK;
            ack_d   = ACK_ONE << grant_s;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ACTIVE;
            bus_valid_d = 1'b1;
            cnt_d       = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACTIVE: begin
        if (bus_done) begin
          state_d     = ACK;
          bus_valid_d = 1'b0;
          ack_d       = ACK_ONE << owner_q;
          err_d       = 1'b0;
          rdata_d     = read_q ? rsp_data : '0;
        end else if (cnt_q == CNT_LAST) begin
          // This was the TIMEOUT-th bus cycle without completion.
          state_d     = ACK;
          bus_valid_d = 1'b0;
          ack_d       = ACK_ONE << owner_q;
          err_d       = 1'b1;
          rdata_d     = '0;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          bus_valid_d = 1'b1;
        end
      end

      ACK: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        // Just-served requester drops to lowest priority.
        rr_ptr_d    = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
      end

      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      tag_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      bus_valid_q <= 1'b0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      read_q      <= read_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      bus_valid_q <= bus_valid_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign req_rdata = rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_write = write_q;
  assign bus_read  = read_q;
  assign bus_tag   = tag_q;
  assign bus_data  = data_q;
  assign bus_owner = owner_q;

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Shared-bus arbiter and transaction sequencer for the snooping-coherence system. It takes read/write requests (write, read, 12-bit tag, 16-bit data) from N processor-side requesters. Round-robin arbitration picks one requester, which is given ownership of the single broadcast snoop bus. The block holds that transaction on the bus until the memory/snoop side signals completion or a timeout expires, then acknowledges the owner.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- TAG_W, 12, tag width
- DATA_W, 16, data width
- TIMEOUT, 15, max ACTIVE cycles waiting for bus_done (>=1)

Ports:
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request
- req_write  in  N_REQ  per-requester write op
- req_read  in  N_REQ  per-requester read op
- req_tag  in  N_REQ*TAG_W  flattened tags; requester i at [i*TAG_W +: TAG_W]
- req_data  in  N_REQ*DATA_W  flattened write data, same packing
- req_ack  out  N_REQ  one-cycle completion pulse to the owner
- req_err  out  1  valid with req_ack: 1 = illegal op or timeout
- req_rdata  out  DATA_W  valid with req_ack: read data (0 for writes/errors)
- bus_valid  out  1  transaction on bus
- bus_write, bus_read  out  1 each  op of the bus transaction
- bus_tag  out  TAG_W
- bus_data  out  DATA_W
- bus_owner  out  clog2(N_REQ)  index of granted requester
- bus_done  in  1  completion from memory/snoop side
- rsp_data  in  DATA_W  read data, sampled with bus_done

## Operation
- States: IDLE, ACTIVE, ACK.
- IDLE: if any req_valid is set, the winner is the first set bit at or after rr_ptr (wrapping). On that edge:
  - latch the winner's write/read/tag/data and its index;
  - if write==read (illegal op), go to ACK with err=1;
  - otherwise go to ACTIVE and clear the timeout counter.
- ACTIVE:
  - bus_valid=1; bus_* fields are held stable from the latched values.
  - bus_done=1 → ACK with err=0; rdata=rsp_data if the op is a read, else 0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with bus_done still 0 → ACK with err=1, rdata=0.
- ACK:
  - req_ack[owner]=1 for exactly one cycle, with req_err/req_rdata valid.
  - bus_valid=0.
  - rr_ptr = (owner+1) mod N_REQ; next state IDLE.
- Requester rule: hold req_valid and its fields stable until req_ack; req_valid must be low in the cycle after req_ack unless it is a new request.
- If req_valid drops while that requester owns the bus: ignored; the latched transaction completes and is acked normally.
- bus_done outside ACTIVE is ignored.
- Reset (any time, including mid-transaction):
  - state IDLE, rr_ptr 0;
  - all outputs 0 (bus_valid, bus_write, bus_read, bus_tag, bus_data, bus_owner, req_ack, req_err, req_rdata);
  - the in-flight transaction is dropped without an ack.

## Timing
- All outputs are registered.
- req_valid sampled at edge k → bus_valid high in cycle k+1.
- bus_done high in cycle k+1 → req_ack in cycle k+2 → IDLE in cycle k+3.
- Minimum 3 cycles per transaction; the next grant is sampled at the end of the IDLE cycle.
- Timeout: bus_valid high for exactly TIMEOUT cycles, then the ACK cycle.
- Illegal op: IDLE → ACK directly; bus_valid never asserts; ack 1 cycle after sampling.
- Ties are resolved only by rr_ptr; a requester that was just served has lowest priority next arbitration.
- bus_owner, bus_write, bus_read, bus_tag and bus_data keep their value through ACK. bus_valid is the only qualifier.

## Structure
- Package snoop_pkg holds:
  - TAG_W=12, DATA_W=16 defaults;
  - state typedef {IDLE, ACTIVE, ACK};
  - op encoding constants (write=10, read=01; 00/11 illegal).
- Sub-module rr_arbiter: combinational, inputs req vector and rr_ptr, outputs grant index and any_req. It is parameterized by N_REQ and instantiated once.
- The top holds the FSM, latch registers, timeout counter and rr_ptr.

## Test plan
- Single read: req 0 read, tag 0x0A5; bus_done with rsp_data 0xBEEF one cycle later → bus_valid 1 cycle, then req_ack=0001, req_rdata=0xBEEF, req_err=0.
- Round-robin: all 4 req_valid held with back-to-back acks, bus_done immediate → bus_owner sequence 0,1,2,3,0; each ack 3 cycles apart.
- Timeout: requester 2 writes data 0x1234 with bus_done never asserted → bus_valid high exactly 15 cycles, then req_ack=0100, req_err=1, rdata=0.
- Illegal op: requester 1 with write=read=1 → no bus_valid; req_ack=0010, req_err=1 one cycle after grant.
- Reset mid-ACTIVE: reset_n low during a write → all outputs 0 immediately, no ack. After release, a request from 3 with rr_ptr=0 is granted to 3.
- Stray bus_done in IDLE and early req_valid drop → no spurious ack; the in-flight transaction still completes with the latched tag/data.
